f2_slide_controller: RTL and testbench

F2_SLIDE_CONTROLLER -- requirements
Module: f2_slide_controller

---
 rtl/f2_slide_controller.sv | 169 ++++++++++++++++
 tb/tb_f2_slide_controller.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/f2_slide_controller.sv
// Image slide controller: manual forwards/backwards navigation with image-load handshake,
// rotation and inversion flags. Optional autoslide timer enabled by macro F2_SLIDE_AUTOSLIDE_EN.
module f2_slide_controller #(
  parameter int NUM_IMAGES  = 8,
  parameter int AUTO_PERIOD = 50_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] f2_button_command,
  input  logic       f2_switch_command,
  input  logic       load_ack,
  output logic [7:0] image_index,
  output logic [1:0] rotation,
  output logic       invert,
  output logic       load_req
);

  typedef enum logic {IDLE = 1'b0, LOAD = 1'b1} state_t;

  localparam logic [7:0] IDX_MAX = 8'(NUM_IMAGES - 1);

  state_t     state_r, state_s;
  logic [3:0] cmd_prev_r;
  logic       start_r;
  logic [7:0] index_s;
  logic [1:0] rotation_s;
  logic       invert_s, load_req_s;
  logic       event_s, fwd_s, bwd_s, rot_s, inv_s;
  logic       auto_step_s;

  function automatic logic [7:0] next_index(input logic [7:0] idx, input logic fwd);
    logic [7:0] res;
    if (fwd) begin
      res = (idx == IDX_MAX) ? 8'd0 : idx + 8'd1;
    end else begin
      res = (idx == 8'd0) ? IDX_MAX : idx - 8'd1;
    end
    return res;
  endfunction

  // Edge-detect the command code and decode it into one-cycle event strobes
  always_comb begin
    fwd_s   = 1'b0;
    bwd_s   = 1'b0;
    rot_s   = 1'b0;
    inv_s   = 1'b0;
    event_s = (f2_button_command != cmd_prev_r);
    if (event_s) begin
      case (f2_button_command)
        4'd1:    bwd_s = 1'b1;
        4'd2:    fwd_s = 1'b1;
        4'd3:    rot_s = 1'b1;
        4'd4:    inv_s = 1'b1;
        default: fwd_s = 1'b0;
      endcase
    end else begin
      fwd_s = 1'b0;
    end
  end

`ifdef F2_SLIDE_AUTOSLIDE_EN
  localparam int CNT_W = (AUTO_PERIOD > 2) ? $clog2(AUTO_PERIOD) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(AUTO_PERIOD - 1);

  logic [CNT_W-1:0] auto_cnt_r, auto_cnt_s;

  // Autoslide interval counter; a manual step always clears it and suppresses expiry
  always_comb begin
    auto_cnt_s  = auto_cnt_r;
    auto_step_s = 1'b0;
    if (!f2_switch_command || fwd_s || bwd_s) begin
      auto_cnt_s = {CNT_W{1'b0}};
    end else if (state_r == LOAD || start_r) begin
      auto_cnt_s = auto_cnt_r;
    end else if (auto_cnt_r == CNT_MAX) begin
      auto_cnt_s  = {CNT_W{1'b0}};
      auto_step_s = 1'b1;
    end else begin
      auto_cnt_s = auto_cnt_r + CNT_W'(1'b1);
    end
  end

  // Autoslide counter register
  always_ff @(posedge clk) begin
    if (reset) begin
      auto_cnt_r <= {CNT_W{1'b0}};
    end else begin
      auto_cnt_r <= auto_cnt_s;
    end
  end
`else
  logic unused_switch_s;
  assign unused_switch_s = f2_switch_command;
  assign auto_step_s     = 1'b0;
`endif

  // Next-state and next-output logic; rotate/invert act in either state
  always_comb begin
    state_s    = state_r;
    index_s    = image_index;
    rotation_s = rotation;
    invert_s   = invert;
    load_req_s = load_req;
    if (rot_s) begin
      rotation_s = rotation + 2'd1;
    end else begin
      rotation_s = rotation;
    end
    if (inv_s) begin
      invert_s = ~invert;
    end else begin
      invert_s = invert;
    end
    case (state_r)
      IDLE: begin
        if (fwd_s || bwd_s) begin
          index_s    = next_index(image_index, fwd_s);
          state_s    = LOAD;
          load_req_s = 1'b1;
        end else if (auto_step_s) begin
          index_s    = next_index(image_index, 1'b1);
          state_s    = LOAD;
          load_req_s = 1'b1;
        end else if (start_r) begin
          state_s    = LOAD;
          load_req_s = 1'b1;
        end else begin
          state_s    = IDLE;
          load_req_s = 1'b0;
        end
      end
      LOAD: begin
        if (load_ack) begin
          state_s    = IDLE;
          load_req_s = 1'b0;
        end else begin
          state_s    = LOAD;
          load_req_s = 1'b1;
        end
      end
      default: begin
        state_s    = IDLE;
        load_req_s = 1'b0;
      end
    endcase
  end

  // State and output registers; start_r requests the initial image load after reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= IDLE;
      cmd_prev_r  <= 4'd0;
      start_r     <= 1'b1;
      image_index <= 8'd0;
      rotation    <= 2'd0;
      invert      <= 1'b0;
      load_req    <= 1'b0;
    end else begin
      state_r     <= state_s;
      cmd_prev_r  <= f2_button_command;
      start_r     <= 1'b0;
      image_index <= index_s;
      rotation    <= rotation_s;
      invert      <= invert_s;
      load_req    <= load_req_s;
    end
  end

endmodule

// File: tb/tb_f2_slide_controller.sv
// Scoreboard bench for f2_slide_controller: expected snapshots and load requests are queued
// by the stimulus and compared by independent monitors on the falling clock edge.
module tb_f2_slide_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] cmd;
  logic       sw;
  logic       ack;
  logic [7:0] image_index;
  logic [1:0] rotation;
  logic       invert;
  logic       load_req;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    string      name;
    logic [7:0] idx;
    logic [1:0] rot;
    logic       inv;
    logic       lreq;
  } snap_t;

  snap_t      snap_q[$];
  logic [7:0] ld_q[$];
  logic       lreq_prev = 1'b0;

  f2_slide_controller #(.NUM_IMAGES(8), .AUTO_PERIOD(4)) dut (
    .clk               (clk),
    .reset             (reset),
    .f2_button_command (cmd),
    .f2_switch_command (sw),
    .load_ack          (ack),
    .image_index       (image_index),
    .rotation          (rotation),
    .invert            (invert),
    .load_req          (load_req)
  );

  always #5 clk = ~clk;

  // Snapshot monitor
  always @(negedge clk) begin
    while (snap_q.size() > 0) begin
      snap_t e;
      e = snap_q.pop_front();
      vectors++;
      if (image_index !== e.idx || rotation !== e.rot || invert !== e.inv || load_req !== e.lreq) begin
        miscompares++;
        $display("FAIL %s: got idx=%0d rot=%0d inv=%0b lreq=%0b, expected idx=%0d rot=%0d inv=%0b lreq=%0b",
                 e.name, image_index, rotation, invert, load_req, e.idx, e.rot, e.inv, e.lreq);
      end
    end
  end

  // Load-request monitor: every new request must fetch the next queued image
  always @(negedge clk) begin
    if (load_req === 1'b1 && lreq_prev !== 1'b1) begin
      vectors++;
      if (ld_q.size() == 0) begin
        miscompares++;
        $display("FAIL load_req: unexpected request for image %0d, expected none", image_index);
      end else begin
        logic [7:0] exp_idx;
        exp_idx = ld_q.pop_front();
        if (image_index !== exp_idx) begin
          miscompares++;
          $display("FAIL load_req: requested image %0d, expected %0d", image_index, exp_idx);
        end
      end
    end
    lreq_prev = load_req;
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_snap(input string name, input logic [7:0] idx, input logic [1:0] rot,
                             input logic inv, input logic lreq);
    snap_t e;
    e.name = name; e.idx = idx; e.rot = rot; e.inv = inv; e.lreq = lreq;
    snap_q.push_back(e);
  endtask

  task automatic pulse_ack();
    ack = 1'b1;
    step(1);
    ack = 1'b0;
  endtask

  initial begin
    reset = 1'b1; cmd = 4'd0; sw = 1'b0; ack = 1'b0;
    step(3);
    expect_snap("reset_state", 8'd0, 2'd0, 1'b0, 1'b0);

    // Reset release: initial load of image 0
    reset = 1'b0;
    ld_q.push_back(8'd0);
    step(1);
    expect_snap("release_load", 8'd0, 2'd0, 1'b0, 1'b1);
    pulse_ack();
    expect_snap("release_ack", 8'd0, 2'd0, 1'b0, 1'b0);

    // Backwards wrap 0 -> 7
    cmd = 4'd1; ld_q.push_back(8'd7);
    step(1);
    expect_snap("bwd_wrap", 8'd7, 2'd0, 1'b0, 1'b1);
    cmd = 4'd0;
    pulse_ack();

    // Forwards held 5 cycles: 7 -> 0 exactly once
    cmd = 4'd2; ld_q.push_back(8'd0);
    step(1);
    expect_snap("fwd_wrap", 8'd0, 2'd0, 1'b0, 1'b1);
    pulse_ack();
    step(3);
    expect_snap("fwd_held", 8'd0, 2'd0, 1'b0, 1'b0);
    cmd = 4'd1; ld_q.push_back(8'd7);
    step(1);
    expect_snap("fwd_to_bwd", 8'd7, 2'd0, 1'b0, 1'b1);

    // In LOAD: forwards discarded, rotate applies, load_req held until ack
    cmd = 4'd2;
    step(1);
    expect_snap("load_fwd_drop", 8'd7, 2'd0, 1'b0, 1'b1);
    cmd = 4'd3;
    step(1);
    expect_snap("load_rotate", 8'd7, 2'd1, 1'b0, 1'b1);
    cmd = 4'd0;
    step(2);
    expect_snap("load_hold", 8'd7, 2'd1, 1'b0, 1'b1);
    pulse_ack();
    expect_snap("load_done", 8'd7, 2'd1, 1'b0, 1'b0);

    // Inverse toggles, illegal codes and stray ack ignored
    cmd = 4'd4;
    step(1);
    expect_snap("invert_on", 8'd7, 2'd1, 1'b1, 1'b0);
    cmd = 4'd0; step(1);
    cmd = 4'd4;
    step(1);
    expect_snap("invert_off", 8'd7, 2'd1, 1'b0, 1'b0);
    cmd = 4'd5; step(1);
    cmd = 4'd15; step(1);
    cmd = 4'd0;
    pulse_ack();
    expect_snap("illegal_codes", 8'd7, 2'd1, 1'b0, 1'b0);

    // Rotation wraps 1 -> 2 -> 3 -> 0
    for (int i = 0; i < 3; i++) begin
      cmd = 4'd3; step(1);
      cmd = 4'd0; step(1);
      if (i == 0) expect_snap("rotate_2", 8'd7, 2'd2, 1'b0, 1'b0);
    end
    expect_snap("rotate_wrap", 8'd7, 2'd0, 1'b0, 1'b0);
    cmd = 4'd4; step(1);
    cmd = 4'd0; step(1);

    // Reset mid-LOAD aborts; ack during reset ignored
    cmd = 4'd1; ld_q.push_back(8'd6);
    step(1);
    expect_snap("pre_reset_load", 8'd6, 2'd0, 1'b1, 1'b1);
    cmd = 4'd0;
    reset = 1'b1;
    step(1);
    expect_snap("mid_load_reset", 8'd0, 2'd0, 1'b0, 1'b0);
    pulse_ack();
    expect_snap("reset_ack_ignored", 8'd0, 2'd0, 1'b0, 1'b0);
    reset = 1'b0; ld_q.push_back(8'd0);
    step(1);
    expect_snap("rerelease_load", 8'd0, 2'd0, 1'b0, 1'b1);
    pulse_ack();
    expect_snap("rerelease_ack", 8'd0, 2'd0, 1'b0, 1'b0);

`ifdef F2_SLIDE_AUTOSLIDE_EN
    // Autoslide every 4 IDLE cycles
    sw = 1'b1;
    step(3);
    expect_snap("auto_wait1", 8'd0, 2'd0, 1'b0, 1'b0);
    ld_q.push_back(8'd1);
    step(1);
    expect_snap("auto_step1", 8'd1, 2'd0, 1'b0, 1'b1);
    pulse_ack();
    step(3);
    expect_snap("auto_wait2", 8'd1, 2'd0, 1'b0, 1'b0);
    ld_q.push_back(8'd2);
    step(1);
    expect_snap("auto_step2", 8'd2, 2'd0, 1'b0, 1'b1);
    pulse_ack();
    sw = 1'b0;
    step(10);
    expect_snap("auto_stopped", 8'd2, 2'd0, 1'b0, 1'b0);

    // Manual backwards on expiry cycle wins: 3 -> 2
    sw = 1'b1;
    ld_q.push_back(8'd3);
    step(4);
    expect_snap("auto_step3", 8'd3, 2'd0, 1'b0, 1'b1);
    pulse_ack();
    step(3);
    expect_snap("auto_wait3", 8'd3, 2'd0, 1'b0, 1'b0);
    cmd = 4'd1; ld_q.push_back(8'd2);
    step(1);
    expect_snap("auto_vs_manual", 8'd2, 2'd0, 1'b0, 1'b1);
    cmd = 4'd0; sw = 1'b0;
    pulse_ack();
    step(6);
    expect_snap("auto_single_step", 8'd2, 2'd0, 1'b0, 1'b0);
`else
    // Without autoslide the switch has no effect
    sw = 1'b1;
    step(100);
    expect_snap("no_autoslide", 8'd0, 2'd0, 1'b0, 1'b0);
    sw = 1'b0;
`endif

    step(2);
    vectors++;
    if (ld_q.size() != 0) begin
      miscompares++;
      $display("FAIL load_queue: %0d expected loads never requested, expected 0", ld_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
